// File: rtl/grid_io_multi_cfg_if.sv
// rtl/grid_io_multi_cfg_if.sv - pad-ring and fabric-side bus of the multi-pad I/O tile
//
// Purpose: groups the per-pad signals of grid_io_multi_cfg into one bundle.
// Signals (NUM_PADS bits each):
//   gfpga_pad_GPIO_A   pad input values from the pad ring
//   gfpga_pad_GPIO_Y   pad output values to the pad ring
//   gfpga_pad_GPIO_OE  pad output enables, 1 = drive
//   pin_outpad         fabric-side data to drive out
//   pin_inpad          fabric-side data received from pads
// slave = the tile, master = pad ring plus fabric.
interface grid_io_multi_cfg_if #(
  parameter int NUM_PADS = 4
);
  logic [NUM_PADS-1:0] gfpga_pad_GPIO_A;
  logic [NUM_PADS-1:0] gfpga_pad_GPIO_Y;
  logic [NUM_PADS-1:0] gfpga_pad_GPIO_OE;
  logic [NUM_PADS-1:0] pin_outpad;
  logic [NUM_PADS-1:0] pin_inpad;

  modport master (
    output gfpga_pad_GPIO_A,
    output pin_outpad,
    input  gfpga_pad_GPIO_Y,
    input  gfpga_pad_GPIO_OE,
    input  pin_inpad
  );

  modport slave (
    input  gfpga_pad_GPIO_A,
    input  pin_outpad,
    output gfpga_pad_GPIO_Y,
    output gfpga_pad_GPIO_OE,
    output pin_inpad
  );
endinterface

// File: rtl/grid_io_multi_cfg.sv
// rtl/grid_io_multi_cfg.sv - multi-pad perimeter I/O tile with scan-loaded, double-buffered configuration
//
// Purpose: NUM_PADS GPIO subtiles, each with its own output enable, output/input
// registering and output polarity, taken from a serial configuration chain. Bits
// are shifted into sreg and copied into a shadow register in a single cycle once
// loading ends, so the pads never run on a half-loaded configuration.
//
// Ports:
//   prog_clk    tile clock (chain shift and registered I/O paths)
//   prog_rst_n  asynchronous active-low reset
//   cfg_en      load enable; the chain shifts one bit per clock while high
//   ccff_head   chain serial in
//   ccff_tail   chain serial out (MSB of the shift register)
//   cfg_valid   last load delivered exactly NUM_PADS*CFG_BITS bits
//   pads        pad-ring (GPIO_A/Y/OE) and fabric (pin_outpad/pin_inpad) bus
//
// Per-pad field, pad p at bits CFG_BITS*p+3..CFG_BITS*p: {inv, ireg, oreg, oe}.
module grid_io_multi_cfg #(
  parameter int NUM_PADS = 4,
  parameter int CFG_BITS = 4,
  parameter int CNT_W    = 8
) (
  input  logic               prog_clk,
  input  logic               prog_rst_n,
  input  logic               cfg_en,
  input  logic               ccff_head,
  output logic               ccff_tail,
  output logic               cfg_valid,
  grid_io_multi_cfg_if.slave pads
);

  localparam int TOTAL = NUM_PADS * CFG_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TOTAL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                do_commit;
  logic                load_active;
  logic [TOTAL-1:0]    sreg_q;
  logic [TOTAL-1:0]    shadow_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                valid_q;

  logic [NUM_PADS-1:0] cfg_oe;
  logic [NUM_PADS-1:0] cfg_oreg;
  logic [NUM_PADS-1:0] cfg_ireg;
  logic [NUM_PADS-1:0] cfg_inv;
  logic [NUM_PADS-1:0] pad_d;
  logic [NUM_PADS-1:0] oreg_q;
  logic [NUM_PADS-1:0] sync1_q;
  logic [NUM_PADS-1:0] sync2_q;

  always_comb begin
    state_d   = state_q;
    do_commit = 1'b0;
    case (state_q)
      IDLE:    if (cfg_en) state_d = SHIFT;
      SHIFT:   if (!cfg_en) state_d = COMMIT;
      COMMIT: begin
        // The commit always completes; a re-raised cfg_en just starts a new load.
        do_commit = 1'b1;
        state_d   = cfg_en ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_en) begin
        sreg_q <= {sreg_q[TOTAL-2:0], ccff_head};
        // Outside SHIFT, cfg_en was low last cycle, so this is the first bit of a load.
        if (state_q != SHIFT) begin
          cnt_q <= CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
      if (do_commit) begin
        shadow_q <= sreg_q;
        valid_q  <= (cnt_q == CNT_TOTAL);
      end else if (cfg_en) begin
        valid_q <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_cfg
    assign cfg_oe[p]   = shadow_q[CFG_BITS*p + 0];
    assign cfg_oreg[p] = shadow_q[CFG_BITS*p + 1];
    assign cfg_ireg[p] = shadow_q[CFG_BITS*p + 2];
    assign cfg_inv[p]  = shadow_q[CFG_BITS*p + 3];
  end

  assign pad_d = pads.pin_outpad ^ cfg_inv;

  // I/O flops clock every cycle so a registering-mode change needs no flush.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      oreg_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      oreg_q  <= pad_d;
      sync1_q <= pads.gfpga_pad_GPIO_A;
      sync2_q <= sync1_q;
    end
  end

  // Covers the first cfg_en cycle too, before state_q has moved to SHIFT.
  assign load_active = cfg_en | (state_q == SHIFT);
  assign cfg_valid   = valid_q & ~load_active;
  assign ccff_tail   = sreg_q[TOTAL-1];

  assign pads.gfpga_pad_GPIO_Y  = (cfg_oreg & oreg_q) | (~cfg_oreg & pad_d);
  assign pads.gfpga_pad_GPIO_OE = cfg_oe & {NUM_PADS{cfg_valid}};
  assign pads.pin_inpad         = (cfg_ireg & sync2_q) | (~cfg_ireg & pads.gfpga_pad_GPIO_A);

endmodule

// File: tb/tb_grid_io_multi_cfg.sv
// tb/tb_grid_io_multi_cfg.sv - self-checking bench for grid_io_multi_cfg
module tb_grid_io_multi_cfg;
  localparam int NP    = 4;
  localparam int CB    = 4;
  localparam int TOTAL = NP * CB;

  logic prog_clk   = 1'b0;
  logic prog_rst_n = 1'b0;
  logic cfg_en     = 1'b0;
  logic ccff_head  = 1'b0;
  logic ccff_tail;
  logic cfg_valid;

  grid_io_multi_cfg_if #(.NUM_PADS(NP)) pads ();

  grid_io_multi_cfg #(.NUM_PADS(NP), .CFG_BITS(CB), .CNT_W(8)) dut (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .cfg_en     (cfg_en),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail),
    .cfg_valid  (cfg_valid),
    .pads       (pads)
  );

  always #5 prog_clk = ~prog_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: every chain bit shifted since reset, A samples at recent edges,
  // the committed per-pad config, and the load bookkeeping.
  bit         hist[$];
  logic [3:0] a_hist[$];
  int         m_cnt;
  bit         m_prev_en;
  bit         m_commit_pend;
  bit         m_valid;
  logic [3:0] m_cfg [NP];
  logic [3:0] m_dlast;

  typedef struct {
    logic [3:0] a;
    logic [3:0] outp;
    logic [3:0] exp_y;
    logic [3:0] exp_oe;
    logic [3:0] exp_in;
  } vec_t;
  vec_t vecs [7];

  function automatic void chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endfunction

  function automatic void chk4(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endfunction

  // Bit k of the shift register = the bit shifted in k shifts ago (0 if none since reset).
  function automatic bit cfg_bit(int k);
    if (hist.size() > k) return hist[hist.size()-1-k];
    return 1'b0;
  endfunction

  function automatic void model_reset();
    hist.delete();
    a_hist.delete();
    m_cnt = 0;
    m_prev_en = 0;
    m_commit_pend = 0;
    m_valid = 0;
    for (int p = 0; p < NP; p++) m_cfg[p] = 4'b0;
    m_dlast = 4'b0;
  endfunction

  function automatic void model_edge();
    logic [3:0] d;
    for (int p = 0; p < NP; p++) d[p] = pads.pin_outpad[p] ^ m_cfg[p][3];
    m_dlast = d;
    a_hist.push_back(pads.gfpga_pad_GPIO_A);
    if (a_hist.size() > 2) void'(a_hist.pop_front());
    if (m_commit_pend) begin
      for (int p = 0; p < NP; p++)
        for (int b = 0; b < CB; b++) m_cfg[p][b] = cfg_bit(CB*p + b);
      m_valid = (m_cnt == TOTAL);
    end else if (cfg_en) begin
      m_valid = 0;
    end
    if (cfg_en) begin
      m_cnt = m_prev_en ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 1;
      hist.push_back(ccff_head);
      if (hist.size() > 2*TOTAL) void'(hist.pop_front());
    end
    m_commit_pend = m_prev_en && !cfg_en;
    m_prev_en = cfg_en;
  endfunction

  task automatic step();
    model_edge();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check_model(string tag);
    logic [3:0] ey, eoe, ein, a_old;
    logic ev;
    #1;
    ev = m_valid && !cfg_en && !m_prev_en;
    a_old = (a_hist.size() >= 2) ? a_hist[a_hist.size()-2] : 4'b0;
    for (int p = 0; p < NP; p++) begin
      eoe[p] = m_cfg[p][0] & ev;
      ey[p]  = m_cfg[p][1] ? m_dlast[p] : (pads.pin_outpad[p] ^ m_cfg[p][3]);
      ein[p] = m_cfg[p][2] ? a_old[p] : pads.gfpga_pad_GPIO_A[p];
    end
    chk1({tag, ".valid"}, cfg_valid, ev);
    chk1({tag, ".tail"}, ccff_tail, cfg_bit(TOTAL-1));
    chk4({tag, ".oe"}, pads.gfpga_pad_GPIO_OE, eoe);
    chk4({tag, ".y"}, pads.gfpga_pad_GPIO_Y, ey);
    chk4({tag, ".inpad"}, pads.pin_inpad, ein);
  endtask

  task automatic load_bits(logic [31:0] w, int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_en = 1'b1;
      ccff_head = w[i];
      check_model("load");
      step();
    end
  endtask

  task automatic finish_load(string tag, logic exp_v, logic [3:0] exp_oe);
    cfg_en = 1'b0;
    ccff_head = 1'b0;
    #1;
    chk1({tag, ".drop_valid"}, cfg_valid, 1'b0);
    step();
    #1;
    chk1({tag, ".commit_valid"}, cfg_valid, 1'b0);
    chk4({tag, ".commit_oe"}, pads.gfpga_pad_GPIO_OE, 4'b0000);
    step();
    #1;
    chk1({tag, ".valid"}, cfg_valid, exp_v);
    chk4({tag, ".oe"}, pads.gfpga_pad_GPIO_OE, exp_oe);
    check_model({tag, ".model"});
  endtask

  task automatic do_reset();
    prog_rst_n = 1'b0;
    cfg_en = 1'b0;
    ccff_head = 1'b0;
    model_reset();
    @(posedge prog_clk);
    #1;
    prog_rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] pat;
    int gap, len, r, rst_at;

    // Config 0x1934: pad3 plain driver, pad2 inverted, pad1 registered out, pad0 2-flop input.
    vecs[0] = '{4'b0000, 4'b1111, 4'b1001, 4'b1110, 4'b0000};
    vecs[1] = '{4'b0001, 4'b1111, 4'b1011, 4'b1110, 4'b0000};
    vecs[2] = '{4'b1110, 4'b0000, 4'b0110, 4'b1110, 4'b1110};
    vecs[3] = '{4'b0000, 4'b0010, 4'b0100, 4'b1110, 4'b0001};
    vecs[4] = '{4'b1011, 4'b0101, 4'b0011, 4'b1110, 4'b1010};
    vecs[5] = '{4'b0100, 4'b1000, 4'b1100, 4'b1110, 4'b0100};
    vecs[6] = '{4'b0000, 4'b0000, 4'b0100, 4'b1110, 4'b0001};

    pads.gfpga_pad_GPIO_A = 4'b0000;
    pads.pin_outpad = 4'b0000;
    #3;
    do_reset();

    // Reset state with no load.
    pads.gfpga_pad_GPIO_A = 4'b1010;
    step();
    step();
    #1;
    chk4("rst_oe", pads.gfpga_pad_GPIO_OE, 4'b0000);
    chk4("rst_y", pads.gfpga_pad_GPIO_Y, 4'b0000);
    chk4("rst_inpad", pads.pin_inpad, 4'b1010);
    chk1("rst_tail", ccff_tail, 1'b0);
    chk1("rst_valid", cfg_valid, 1'b0);

    // Full load, then data paths via the vector table.
    pads.gfpga_pad_GPIO_A = 4'b0000;
    load_bits(32'h1934, 16);
    finish_load("load16", 1'b1, 4'b1110);
    for (int i = 0; i < 7; i++) begin
      pads.gfpga_pad_GPIO_A = vecs[i].a;
      pads.pin_outpad = vecs[i].outp;
      #1;
      chk4($sformatf("vec%0d.y", i), pads.gfpga_pad_GPIO_Y, vecs[i].exp_y);
      chk4($sformatf("vec%0d.oe", i), pads.gfpga_pad_GPIO_OE, vecs[i].exp_oe);
      chk4($sformatf("vec%0d.inpad", i), pads.pin_inpad, vecs[i].exp_in);
      step();
    end

    // Short load then a correct load.
    load_bits(32'h1934, 15);
    finish_load("short15", 1'b0, 4'b0000);
    load_bits(32'h1934, 16);
    finish_load("reload16", 1'b1, 4'b1110);

    // Long load: chain pass-through on ccff_tail.
    pat = $urandom;
    for (int k = 0; k < 32; k++) begin
      cfg_en = 1'b1;
      ccff_head = pat[k];
      step();
      if (k + 1 >= 16) begin
        #1;
        chk1($sformatf("tail_k%0d", k + 1), ccff_tail, pat[k + 1 - 16]);
      end
    end
    finish_load("long32", 1'b0, 4'b0000);

    // 272 shifts: a wrapping counter would read 16 here; saturation must keep it invalid.
    for (int k = 0; k < 272; k++) begin
      cfg_en = 1'b1;
      ccff_head = 1'($urandom);
      step();
    end
    finish_load("sat272", 1'b0, 4'b0000);

    // Reset in the middle of a load over a valid config.
    load_bits(32'h1994, 16);
    finish_load("pre_rst", 1'b1, 4'b1110);
    load_bits(32'hFF, 8);
    #1;
    chk1("mid_tail", ccff_tail, 1'b1);
    chk4("mid_oe", pads.gfpga_pad_GPIO_OE, 4'b0000);
    prog_rst_n = 1'b0;
    model_reset();
    #1;
    chk4("rst_mid_oe", pads.gfpga_pad_GPIO_OE, 4'b0000);
    chk1("rst_mid_valid", cfg_valid, 1'b0);
    chk1("rst_mid_tail", ccff_tail, 1'b0);
    cfg_en = 1'b0;
    @(posedge prog_clk);
    #1;
    prog_rst_n = 1'b1;
    load_bits(32'h1934, 16);
    finish_load("post_rst", 1'b1, 4'b1110);

    // One-cycle cfg_en drop: commit completes, new load restarts the counter.
    do_reset();
    pads.pin_outpad = 4'b0000;
    load_bits(32'h1934, 16);
    cfg_en = 1'b0;
    step();
    cfg_en = 1'b1;
    ccff_head = 1'b0;
    #1;
    chk4("pulse_commit_oe", pads.gfpga_pad_GPIO_OE, 4'b0000);
    step();
    #1;
    chk4("pulse_shift_oe", pads.gfpga_pad_GPIO_OE, 4'b0000);
    chk1("pulse_shift_valid", cfg_valid, 1'b0);
    chk4("pulse_shift_y", pads.gfpga_pad_GPIO_Y, 4'b0100);
    load_bits(32'h1934, 15);
    finish_load("pulse_reload", 1'b1, 4'b1110);

    // Randomized loads, gaps, pad traffic and occasional resets against the model.
    for (int ep = 0; ep < 250; ep++) begin
      gap = $urandom_range(0, 3);
      cfg_en = 1'b0;
      ccff_head = 1'b0;
      for (int g = 0; g <= gap; g++) begin
        pads.gfpga_pad_GPIO_A = 4'($urandom);
        pads.pin_outpad = 4'($urandom);
        check_model("rnd_idle");
        step();
      end
      r = $urandom_range(0, 9);
      len = (r < 6) ? 16 : (r == 6) ? 15 : (r == 7) ? 17 : $urandom_range(1, 40);
      rst_at = ($urandom_range(0, 24) == 0) ? $urandom_range(0, len - 1) : -1;
      for (int i = 0; i < len; i++) begin
        cfg_en = 1'b1;
        ccff_head = 1'($urandom);
        pads.gfpga_pad_GPIO_A = 4'($urandom);
        pads.pin_outpad = 4'($urandom);
        if (i == rst_at) begin
          prog_rst_n = 1'b0;
          model_reset();
          cfg_en = 1'b0;
          check_model("rnd_rst");
          @(posedge prog_clk);
          #1;
          prog_rst_n = 1'b1;
          break;
        end
        check_model("rnd_shift");
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
